// File: rtl/fetch_unit.sv
// Instruction fetch stage and program counter: fetches one word over a req/ack handshake,
// presents op/instr to control, then updates the PC from control's inc/load/halt.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [2:0]        op,
  output logic              instr_valid,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              halt,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StUpdate,
    StHalted
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              req_q;
  logic              valid_q;
  logic              halted_q;

  // All outputs are registered alongside the state so control sees glitch-free values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          req_q   <= 1'b1;
        end
        StFetch: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StUpdate;
        end
        StUpdate: begin
          valid_q <= 1'b0;
          if (halt) begin
            halted_q <= 1'b1;
            state_q  <= StHalted;
          end else begin
            // A jump arrives with inc_pc also set, so load_pc must win.
            if (load_pc) begin
              pc_q <= jump_target;
            end else if (inc_pc) begin
              pc_q <= pc_q + ADDR_W'(1);
            end
            req_q   <= 1'b1;
            state_q <= StFetch;
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[DATA_W-1 -: 3];
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: emulates memory and control, checks against a PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [2:0]  op;
  logic        instr_valid;
  logic        inc_pc = 1'b0;
  logic        load_pc = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] jump_target = '0;
  logic [15:0] pc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .instr_valid(instr_valid),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .halt       (halt),
    .jump_target(jump_target),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; imem_ack = 1'b0; inc_pc = 1'b0; load_pc = 1'b0; halt = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Memory + control emulation for one instruction; control values are applied once the
  // fetch is visible, so they stay stable through that instruction's update cycle.
  task automatic serve(input logic [15:0] word, input int waits, input logic inc,
                       input logic ld, input logic hl, input logic [15:0] tgt,
                       output logic [15:0] addr, output bit ok);
    ok = 1'b0;
    addr = 'x;
    for (int n = 0; n < 20 && imem_req !== 1'b1; n++) step();
    if (imem_req !== 1'b1) return;
    inc_pc = inc; load_pc = ld; halt = hl; jump_target = tgt;
    addr = imem_addr;
    repeat (waits) step();
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    step();
    step();
    total += 6;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    if (op !== 3'd0) begin bad++; $display("FAIL reset_op: got %0d expected 0", op); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
    reset = 1'b1; imem_ack = 1'b0;
    step();
    total += 2;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b expected 1", imem_req); end
    if (imem_addr !== 16'h0000) begin bad++; $display("FAIL first_addr: got %h expected 0000", imem_addr); end
  endtask

  task automatic test_sequential();
    int valid_cnt = 0;
    reset = 1'b0; imem_ack = 1'b0; inc_pc = 1'b1; load_pc = 1'b0; halt = 1'b0;
    step();
    step();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h0000;
    for (int k = 1; k <= 15; k++) begin
      int phase = (k - 1) % 3;
      logic [15:0] n = 16'((k - 1) / 3);
      step();
      if (instr_valid === 1'b1) valid_cnt++;
      total += 3;
      if (imem_req !== (phase == 0)) begin
        bad++; $display("FAIL seq_req k=%0d: got %b expected %b", k, imem_req, phase == 0);
      end
      if (instr_valid !== (phase != 0)) begin
        bad++; $display("FAIL seq_valid k=%0d: got %b expected %b", k, instr_valid, phase != 0);
      end
      if (pc !== n) begin bad++; $display("FAIL seq_pc k=%0d: got %h expected %h", k, pc, n); end
      if (phase == 0) begin
        total++;
        if (imem_addr !== n) begin
          bad++; $display("FAIL seq_addr k=%0d: got %h expected %h", k, imem_addr, n);
        end
      end
    end
    imem_ack = 1'b0;
    total++;
    if (valid_cnt != 10) begin bad++; $display("FAIL seq_valid_count: got %0d expected 10", valid_cnt); end
  endtask

  task automatic test_wait_states();
    logic [15:0] a;
    bit ok;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      serve(16'h1000 + 16'(i), 0, 1'b1, 1'b0, 1'b0, 16'h0, a, ok);
      total++;
      if (ok !== 1'b1 || a !== 16'(i)) begin
        bad++; $display("FAIL wait_pre_addr%0d: got %h ok=%b expected %h", i, a, ok, 16'(i));
      end
    end
    for (int n = 0; n < 20 && imem_req !== 1'b1; n++) step();
    for (int c = 0; c < 4; c++) begin
      total += 3;
      if (imem_req !== 1'b1) begin bad++; $display("FAIL wait_req c=%0d: got %b expected 1", c, imem_req); end
      if (imem_addr !== 16'h0003) begin
        bad++; $display("FAIL wait_addr c=%0d: got %h expected 0003", c, imem_addr);
      end
      if (instr !== 16'h1002) begin bad++; $display("FAIL wait_instr c=%0d: got %h expected 1002", c, instr); end
      step();
    end
    imem_ack = 1'b1; imem_rdata = 16'hA5C3;
    total += 2;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL wait_req_ackcyc: got %b expected 1", imem_req); end
    if (instr !== 16'h1002) begin bad++; $display("FAIL wait_instr_ackcyc: got %h expected 1002", instr); end
    step();
    imem_ack = 1'b0;
    total += 4;
    if (instr !== 16'hA5C3) begin bad++; $display("FAIL wait_capture: got %h expected a5c3", instr); end
    if (op !== 3'd5) begin bad++; $display("FAIL wait_op: got %0d expected 5", op); end
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL wait_valid: got %b expected 1", instr_valid); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL wait_req_drop: got %b expected 0", imem_req); end
  endtask

  task automatic test_jump();
    logic [15:0] a;
    bit ok;
    apply_reset();
    serve(16'h8000, 0, 1'b1, 1'b1, 1'b0, 16'h0123, a, ok);
    total += 2;
    if (ok !== 1'b1 || a !== 16'h0000) begin bad++; $display("FAIL jump_src: got %h expected 0000", a); end
    if (op !== 3'd4) begin bad++; $display("FAIL jump_op: got %0d expected 4", op); end
    serve(16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h0, a, ok);
    total += 2;
    if (ok !== 1'b1 || a !== 16'h0123) begin bad++; $display("FAIL jump_addr: got %h expected 0123", a); end
    if (pc !== 16'h0123) begin bad++; $display("FAIL jump_pc: got %h expected 0123", pc); end
  endtask

  task automatic test_halt();
    logic [15:0] a;
    bit ok;
    apply_reset();
    for (int i = 0; i < 5; i++) serve(16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h0, a, ok);
    serve(16'hE000, 0, 1'b0, 1'b0, 1'b1, 16'h0, a, ok);
    total++;
    if (ok !== 1'b1 || a !== 16'h0005) begin bad++; $display("FAIL halt_addr: got %h expected 0005", a); end
    step();
    step();
    for (int c = 0; c < 20; c++) begin
      total += 6;
      if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag c=%0d: got %b expected 1", c, halted); end
      if (pc !== 16'h0005) begin bad++; $display("FAIL halt_pc c=%0d: got %h expected 0005", c, pc); end
      if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req c=%0d: got %b expected 0", c, imem_req); end
      if (instr !== 16'hE000) begin bad++; $display("FAIL halt_instr c=%0d: got %h expected e000", c, instr); end
      if (op !== 3'd7) begin bad++; $display("FAIL halt_op c=%0d: got %0d expected 7", c, op); end
      if (instr_valid !== 1'b0) begin
        bad++; $display("FAIL halt_valid c=%0d: got %b expected 0", c, instr_valid);
      end
      imem_ack = (c % 5 == 2);
      imem_rdata = 16'($urandom);
      step();
    end
    imem_ack = 1'b0;
    halt = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] a;
    bit ok;
    apply_reset();
    serve(16'h8000, 0, 1'b0, 1'b1, 1'b0, 16'hFFFF, a, ok);
    serve(16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h0, a, ok);
    total++;
    if (ok !== 1'b1 || a !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre: got %h expected ffff", a); end
    serve(16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h0, a, ok);
    total += 2;
    if (ok !== 1'b1 || a !== 16'h0000) begin bad++; $display("FAIL wrap_addr: got %h expected 0000", a); end
    if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc: got %h expected 0000", pc); end
  endtask

  task automatic test_reset_midfetch();
    logic [15:0] a;
    bit ok;
    apply_reset();
    serve(16'h2222, 0, 1'b1, 1'b0, 1'b0, 16'h0, a, ok);
    serve(16'h3333, 0, 1'b1, 1'b0, 1'b0, 16'h0, a, ok);
    for (int n = 0; n < 20 && imem_req !== 1'b1; n++) step();
    step();
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      bad++; $display("FAIL mid_pending: got req=%b addr=%h expected req=1 addr=0002", imem_req, imem_addr);
    end
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h7777;
    step();
    total += 5;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %b expected 0", imem_req); end
    if (pc !== 16'h0000) begin bad++; $display("FAIL mid_pc: got %h expected 0000", pc); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
    if (instr !== 16'h0000) begin bad++; $display("FAIL mid_instr: got %h expected 0000", instr); end
    if (halted !== 1'b0) begin bad++; $display("FAIL mid_halted: got %b expected 0", halted); end
    step();
    total++;
    if (instr !== 16'h0000) begin bad++; $display("FAIL mid_ack_ignored: got %h expected 0000", instr); end
    reset = 1'b1; imem_ack = 1'b0;
    step();
    total += 2;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_restart_req: got %b expected 1", imem_req); end
    if (imem_addr !== 16'h0000) begin
      bad++; $display("FAIL mid_restart_addr: got %h expected 0000", imem_addr);
    end
  endtask

  task automatic test_random();
    logic [15:0] pc_m = 16'h0000;
    logic [15:0] a;
    logic [15:0] word;
    logic [15:0] tgt;
    logic [2:0]  op_m;
    logic        inc;
    logic        ld;
    bit          ok;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      word = 16'($urandom);
      inc  = 1'($urandom_range(0, 3) != 0);
      ld   = 1'($urandom_range(0, 3) == 0);
      tgt  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom);
      serve(word, int'($urandom_range(0, 3)), inc, ld, 1'b0, tgt, a, ok);
      op_m = word[15:13];
      total += 4;
      if (ok !== 1'b1) begin bad++; $display("FAIL rnd_timeout i=%0d: got no request expected one", i); end
      if (a !== pc_m) begin bad++; $display("FAIL rnd_addr i=%0d: got %h expected %h", i, a, pc_m); end
      if (instr !== word) begin bad++; $display("FAIL rnd_instr i=%0d: got %h expected %h", i, instr, word); end
      if (op !== op_m) begin bad++; $display("FAIL rnd_op i=%0d: got %0d expected %0d", i, op, op_m); end
      if (ld) pc_m = tgt;
      else if (inc) pc_m = pc_m + 16'd1;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_jump();
    test_halt();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
